// File: rtl/ysyx_25030093_lsu_pkg.sv
// rtl/ysyx_25030093_lsu_pkg.sv - LSU state encoding and RV32I load/store funct3 codes
package ysyx_25030093_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/ysyx_25030093_lsu_align.sv
// rtl/ysyx_25030093_lsu_align.sv - combinational store lane formatting, load extract/extend, misalign detect
module ysyx_25030093_lsu_align
  import ysyx_25030093_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_misalign
);

  logic [15:0] w_shift;
  logic        w_half;
  logic        w_byte;

  assign w_shift = 16'(i_rdata >> {i_off, 3'b000});
  assign w_half  = (i_funct3 == F3_LH) || (i_funct3 == F3_LHU);
  assign w_byte  = (i_funct3 == F3_LB) || (i_funct3 == F3_LBU);
  assign o_misalign = w_half ? i_off[0] : (!w_byte && (i_off != 2'd0));

  always_comb begin
    o_wmask = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3)
      F3_SB: begin
        o_wmask = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_SH: begin
        o_wmask = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_SW:   o_wmask = 4'b1111;
      default: o_wmask = 4'b1111;
    endcase
  end

  // Word and unused codes take the aligned word unshifted.
  always_comb begin
    o_ldata = i_rdata;
    case (i_funct3)
      F3_LB:   o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LH:   o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LBU:  o_ldata = {24'd0, w_shift[7:0]};
      F3_LHU:  o_ldata = {16'd0, w_shift[15:0]};
      F3_LW:   o_ldata = i_rdata;
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_lsu.sv
// rtl/ysyx_25030093_lsu.sv - load/store unit FSM; YSYX_25030093_LSU_MISALIGN_CHECK_EN traps misaligned half/word accesses
module ysyx_25030093_lsu
  import ysyx_25030093_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [2:0]        funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] LSU_data,
  output logic              rd_or_LSU_single,
  output logic              out_err
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic [1:0]        r_off;
  logic [2:0]        r_funct3;
  logic              r_is_load;
  logic              r_err;
  logic [DATA_W-1:0] r_ldata;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_trap;
  logic        w_misalign;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_accept = in_valid && in_ready;
  assign w_is_mem = mem_ren || mem_wen;

  // In IDLE the formatter sees the live instruction; afterwards, the latched one.
  assign w_f3  = (r_state == S_IDLE) ? funct3 : r_funct3;
  assign w_off = (r_state == S_IDLE) ? addr[1:0] : r_off;

  ysyx_25030093_lsu_align u_align (
    .i_funct3   (w_f3),
    .i_off      (w_off),
    .i_wdata    (wdata),
    .i_rdata    (mem_rsp_data),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata),
    .o_misalign (w_misalign)
  );

`ifdef YSYX_25030093_LSU_MISALIGN_CHECK_EN
  assign w_trap  = w_is_mem && w_misalign;
  assign out_err = (r_state == S_DONE) && r_err;
`else
  logic w_unused_misalign;
  assign w_unused_misalign = w_misalign;
  assign w_trap  = 1'b0;
  assign out_err = 1'b0;
`endif

  assign in_ready         = (r_state == S_IDLE);
  assign mem_req_valid    = (r_state == S_REQ);
  assign out_valid        = (r_state == S_DONE);
  assign LSU_data         = r_ldata;
  assign rd_or_LSU_single = (r_state == S_DONE) && r_is_load && !r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = (w_is_mem && !w_trap) ? S_REQ : S_DONE;
      S_REQ:  if (mem_req_ready) w_next = S_WAIT;
      S_WAIT: if (mem_rsp_valid) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_off         <= 2'd0;
      r_funct3      <= 3'd0;
      r_is_load     <= 1'b0;
      r_err         <= 1'b0;
      r_ldata       <= '0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= 4'd0;
    end else begin
      if (w_accept) begin
        r_off         <= addr[1:0];
        r_funct3      <= funct3;
        r_is_load     <= mem_ren;
        r_err         <= w_trap;
        r_ldata       <= '0;
        mem_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem_req_wen   <= mem_wen && !mem_ren;
        mem_req_wdata <= w_wdata;
        mem_req_wmask <= (mem_wen && !mem_ren) ? w_wmask : 4'd0;
      end
      if ((r_state == S_WAIT) && mem_rsp_valid && r_is_load)
        r_ldata <= w_ldata;
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// tb/tb_ysyx_25030093_lsu.sv - self-checking bench for ysyx_25030093_lsu with a behavioural load/store model
module tb_ysyx_25030093_lsu;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, mem_ren, mem_wen;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data, LSU_data;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, out_valid, out_ready, rd_or_LSU_single, out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25030093_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .wdata(wdata), .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .LSU_data(LSU_data),
    .rd_or_LSU_single(rd_or_LSU_single), .out_err(out_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] rsp);
    logic [31:0] sh;
    sh = rsp >> (8 * o);
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b001:  return 32'($signed(sh[15:0]));
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return rsp;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] o);
    logic [7:0] m;
    if (f3 == 3'b000)      m = 8'h01 << o;
    else if (f3 == 3'b001) m = 8'h03 << o;
    else                   m = 8'h0F;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'b000)      return wd[7:0] * 32'h0101_0101;
    else if (f3 == 3'b001) return wd[15:0] * 32'h0001_0001;
    else                   return wd;
  endfunction

  // Drives one memory instruction through the DUT and captures what it saw; the callers compare.
  task automatic run_mem(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                         input int rdy_dly, input int rsp_dly, input int hold,
                         output logic [31:0] q_addr, output logic [31:0] q_wdata,
                         output logic [3:0] q_mask, output logic q_wen, output logic q_req_at,
                         output logic q_stable, output logic q_early, output logic q_valid_at,
                         output logic [31:0] q_ldata, output logic q_rd, output logic q_err,
                         output logic q_held, output logic q_timeout);
    int n;
    q_stable = 1'b1; q_early = 1'b0; q_held = 1'b1; q_timeout = 1'b0;
    in_valid = 1'b1; mem_ren = ren; mem_wen = wen; funct3 = f3; addr = a; wdata = wd;
    step();
    in_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    mem_ren = 1'($urandom); mem_wen = 1'($urandom);
    q_req_at = mem_req_valid;
    q_addr = mem_req_addr; q_wdata = mem_req_wdata; q_mask = mem_req_wmask; q_wen = mem_req_wen;
    mem_req_ready = 1'b0;
    repeat (rdy_dly) begin
      if (out_valid) q_early = 1'b1;
      step();
      if (mem_req_valid !== 1'b1 || mem_req_addr !== q_addr || mem_req_wdata !== q_wdata ||
          mem_req_wmask !== q_mask || mem_req_wen !== q_wen) q_stable = 1'b0;
    end
    if (out_valid) q_early = 1'b1;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    repeat (rsp_dly - 1) begin
      if (out_valid) q_early = 1'b1;
      step();
    end
    if (out_valid) q_early = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = rsp;
    if (hold > 0) out_ready = 1'b0;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
    q_valid_at = out_valid; q_ldata = LSU_data; q_rd = rd_or_LSU_single; q_err = out_err;
    if (hold > 0) begin
      in_valid = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0;
      repeat (hold) begin
        step();
        if (out_valid !== 1'b1 || LSU_data !== q_ldata || in_ready !== 1'b0 ||
            mem_req_valid !== 1'b0) q_held = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    n = 0;
    step();
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) begin
      q_timeout = 1'b1;
      rst = 1'b1; step(); rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [139:0] got, exp;
    rst = 1'b1; in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'd0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    got = {in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
           out_valid, LSU_data, rd_or_LSU_single, out_err, 32'd0};
    exp = {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_values: got %h expected %h", got, exp); end
  endtask

  task automatic test_nonmem();
    in_valid = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, mem_req_valid, rd_or_LSU_single} !== 4'b1000 || LSU_data !== 32'd0) begin
      errors++;
      $display("FAIL nonmem_t1: got v/ir/req/rd=%b data=%h expected 1000 data=0",
               {out_valid, in_ready, mem_req_valid, rd_or_LSU_single}, LSU_data);
    end
    step();
    checks++;
    if ({out_valid, in_ready, mem_req_valid} !== 3'b010) begin
      errors++;
      $display("FAIL nonmem_t2: got v/ir/req=%b expected 010", {out_valid, in_ready, mem_req_valid});
    end
  endtask

  task automatic test_lb();
    logic [31:0] qa, qw, ql; logic [3:0] qm;
    logic qwen, qreq, qst, qe, qv, qrd, qerr, qh, qto;
    run_mem(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 1, 0,
            qa, qw, qm, qwen, qreq, qst, qe, qv, ql, qrd, qerr, qh, qto);
    checks++;
    if (qa !== 32'h8000_0000) begin errors++; $display("FAIL lb_addr: got %h expected 80000000", qa); end
    checks++;
    if (ql !== 32'hFFFF_FF80 || qrd !== 1'b1 || qv !== 1'b1) begin
      errors++; $display("FAIL lb_data: got %h rd=%b v=%b expected ffffff80 rd=1 v=1", ql, qrd, qv);
    end
    run_mem(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 1, 0,
            qa, qw, qm, qwen, qreq, qst, qe, qv, ql, qrd, qerr, qh, qto);
    checks++;
    if (ql !== 32'h0000_0080 || qrd !== 1'b1) begin
      errors++; $display("FAIL lbu_data: got %h rd=%b expected 00000080 rd=1", ql, qrd);
    end
  endtask

  task automatic test_sh();
    logic [31:0] qa, qw, ql; logic [3:0] qm;
    logic qwen, qreq, qst, qe, qv, qrd, qerr, qh, qto;
    run_mem(0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 1, 0,
            qa, qw, qm, qwen, qreq, qst, qe, qv, ql, qrd, qerr, qh, qto);
    checks++;
    if (qwen !== 1'b1 || qm !== 4'b1100 || qw !== 32'hABCD_ABCD) begin
      errors++; $display("FAIL sh_req: got wen=%b mask=%b wdata=%h expected 1 1100 abcdabcd", qwen, qm, qw);
    end
    checks++;
    if (ql !== 32'd0 || qrd !== 1'b0 || qv !== 1'b1) begin
      errors++; $display("FAIL sh_done: got data=%h rd=%b v=%b expected 0 0 1", ql, qrd, qv);
    end
  endtask

  task automatic test_req_stall();
    logic [31:0] qa, qw, ql, a, rsp; logic [3:0] qm;
    logic qwen, qreq, qst, qe, qv, qrd, qerr, qh, qto;
    a = {$urandom, 2'b00} & 32'hFFFF_FFFC; rsp = $urandom;
    run_mem(1, 0, 3'b010, a, 32'h0, rsp, 3, 2, 0,
            qa, qw, qm, qwen, qreq, qst, qe, qv, ql, qrd, qerr, qh, qto);
    checks++;
    if (qst !== 1'b1 || qreq !== 1'b1 || qa !== a) begin
      errors++; $display("FAIL stall_fields: got stable=%b req=%b addr=%h expected 1 1 %h", qst, qreq, qa, a);
    end
    checks++;
    if (qe !== 1'b0 || qv !== 1'b1 || ql !== rsp) begin
      errors++; $display("FAIL stall_timing: got early=%b v=%b data=%h expected 0 1 %h", qe, qv, ql, rsp);
    end
  endtask

  task automatic test_out_stall();
    logic [31:0] qa, qw, ql, rsp; logic [3:0] qm;
    logic qwen, qreq, qst, qe, qv, qrd, qerr, qh, qto;
    rsp = $urandom;
    run_mem(1, 0, 3'b001, 32'h8000_0102, 32'h0, rsp, 0, 1, 4,
            qa, qw, qm, qwen, qreq, qst, qe, qv, ql, qrd, qerr, qh, qto);
    checks++;
    if (qh !== 1'b1 || qv !== 1'b1 || ql !== model_load(3'b001, 2'd2, rsp)) begin
      errors++; $display("FAIL out_stall_hold: got held=%b v=%b data=%h expected 1 1 %h",
                         qh, qv, ql, model_load(3'b001, 2'd2, rsp));
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || qto !== 1'b0) begin
      errors++; $display("FAIL out_stall_release: got v=%b ir=%b to=%b expected 0 1 0", out_valid, in_ready, qto);
    end
  endtask

  task automatic test_reset_wait();
    logic [107:0] got, exp;
    logic seen;
    in_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; funct3 = 3'b010; addr = 32'h8000_0040;
    step();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    got = {in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
           out_valid, LSU_data, rd_or_LSU_single, out_err};
    exp = {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_in_wait: got %h expected %h", got, exp); end
    mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
    step();
    mem_rsp_valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL late_rsp: got spurious activity=%b expected 0", seen); end
  endtask

`ifdef YSYX_25030093_LSU_MISALIGN_CHECK_EN
  task automatic test_misalign();
    in_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; funct3 = 3'b010; addr = 32'h8000_0001;
    step();
    in_valid = 1'b0;
    checks++;
    if ({mem_req_valid, out_valid, out_err, rd_or_LSU_single} !== 4'b0110 || LSU_data !== 32'd0) begin
      errors++; $display("FAIL misalign_lw: got req/v/err/rd=%b data=%h expected 0110 0",
                         {mem_req_valid, out_valid, out_err, rd_or_LSU_single}, LSU_data);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_err !== 1'b0) begin
      errors++; $display("FAIL misalign_release: got ir=%b err=%b expected 1 0", in_ready, out_err);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] qa, qw, ql, a, wd, rsp, el; logic [3:0] qm;
    logic qwen, qreq, qst, qe, qv, qrd, qerr, qh, qto, ren, wen;
    logic [2:0] f3; logic [1:0] o;
    logic [2:0] ltab [5];
    bit macro_on;
    ltab[0] = 3'b000; ltab[1] = 3'b001; ltab[2] = 3'b010; ltab[3] = 3'b100; ltab[4] = 3'b101;
`ifdef YSYX_25030093_LSU_MISALIGN_CHECK_EN
    macro_on = 1'b1;
`else
    macro_on = 1'b0;
`endif
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      ren = (kind != 1); wen = (kind != 0);
      f3 = ren ? ltab[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      o = 2'($urandom);
      if (f3[1:0] == 2'b01) begin
        if (macro_on) o[0] = 1'b0;
        else if (ren && o == 2'd3) o = 2'd1;
      end else if (f3[1:0] != 2'b00) begin
        if (ren || macro_on) o = 2'd0;
      end
      a = {$urandom, 2'b00} | {30'd0, o};
      a[1:0] = o;
      wd = $urandom; rsp = $urandom;
      run_mem(ren, wen, f3, a, wd, rsp, $urandom_range(0, 3), $urandom_range(1, 3), 0,
              qa, qw, qm, qwen, qreq, qst, qe, qv, ql, qrd, qerr, qh, qto);
      el = ren ? model_load(f3, o, rsp) : 32'd0;
      checks++;
      if (qreq !== 1'b1 || qa !== {a[31:2], 2'b00} || qwen !== (wen && !ren) || qst !== 1'b1) begin
        errors++; $display("FAIL rnd_req[%0d]: got req=%b addr=%h wen=%b stable=%b expected 1 %h %b 1",
                           i, qreq, qa, qwen, qst, {a[31:2], 2'b00}, wen && !ren);
      end
      if (!ren) begin
        checks++;
        if (qm !== model_mask(f3, o) || qw !== model_wdata(f3, wd)) begin
          errors++; $display("FAIL rnd_store[%0d]: got mask=%b wdata=%h expected %b %h",
                             i, qm, qw, model_mask(f3, o), model_wdata(f3, wd));
        end
      end
      checks++;
      if (qe !== 1'b0 || qv !== 1'b1 || ql !== el || qrd !== ren || qerr !== 1'b0 || qto !== 1'b0) begin
        errors++; $display("FAIL rnd_result[%0d]: got early=%b v=%b data=%h rd=%b err=%b to=%b expected 0 1 %h %b 0 0",
                           i, qe, qv, ql, qrd, qerr, qto, el, ren);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_lb();
    test_nonmem();
    test_sh();
    test_req_stall();
    test_out_stall();
    test_reset_wait();
`ifdef YSYX_25030093_LSU_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    test_nonmem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
